i2c_slave_ctrl: RTL and testbench

- I2C slave protocol engine; sits directly upstream of the 16x8 register file (dram) and drives its chip-select, read/write, address and write data ports.
- Oversamples SCL/SDA on the system clock, detects START/STOP and decodes the 7-bit device address.
- Decodes a register-pointer byte and converts bus writes and reads into register-file accesses with pointer auto-increment.
- Drives SDA open-drain for ACK and read data.

---
 rtl/i2c_slave_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol engine in front of a 16x8 register file.
// Oversamples SCL/SDA, detects START/STOP, decodes the device address and a register
// pointer, and turns bus writes/reads into single-cycle register-file strobes with
// pointer auto-increment. SDA is driven open-drain via o_sda_oe.
// Optional feature: define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-cycle glitch filter
// on both lines after the synchronizers.
module i2c_slave_ctrl #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic       i_ck,
   input  logic       i_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oe,
   output logic       o_csn,
   output logic       o_rw,
   output logic [3:0] o_address,
   output logic [7:0] o_data,
   input  logic [7:0] i_rdata,
   output logic       o_busy
);

   if (FILTER_LEN == 0) begin : g_bad_filter_len
      $error("FILTER_LEN must be at least 1");
   end

   typedef enum logic [3:0] {
      StIdle,
      StDevAddr,
      StAckAddr,
      StRegPtr,
      StAckPtr,
      StWData,
      StAckWData,
      StRdFetch,
      StRData,
      StRAck
   } state_e;

   // Bit 1 = SCL, bit 0 = SDA throughout the conditioning path.
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] line;
   logic [1:0] line_p_q;

   // Two-flop synchronizer; idle-high reset avoids false edges after reset.
   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {i_scl, i_sda};
         sync2_q <= sync1_q;
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   localparam int unsigned FltW = $clog2(FILTER_LEN + 1);

   logic [1:0]      flt_q;
   logic [FltW-1:0] flt_cnt_q [2];

   // Accept a new line level only after it has been stable for FILTER_LEN cycles.
   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         flt_q        <= 2'b11;
         flt_cnt_q[0] <= '0;
         flt_cnt_q[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == flt_q[i]) begin
               flt_cnt_q[i] <= '0;
            end else if (flt_cnt_q[i] == FltW'(FILTER_LEN - 1)) begin
               flt_q[i]     <= sync2_q[i];
               flt_cnt_q[i] <= '0;
            end else begin
               flt_cnt_q[i] <= flt_cnt_q[i] + FltW'(1);
            end
         end
      end
   end

   assign line = flt_q;
`else
   assign line = sync2_q;
`endif

   // Previous conditioned levels for edge detection.
   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         line_p_q <= 2'b11;
      end else begin
         line_p_q <= line;
      end
   end

   logic scl_f, sda_f, scl_p, sda_p;
   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_f     = line[1];
   assign sda_f     = line[0];
   assign scl_p     = line_p_q[1];
   assign sda_p     = line_p_q[0];
   assign scl_rise  = scl_f & ~scl_p;
   assign scl_fall  = ~scl_f & scl_p;
   assign start_det = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

   state_e     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] rd_sh_q, rd_sh_d;
   logic [3:0] ptr_q, ptr_d;
   logic       rw_bit_q, rw_bit_d;
   logic       sda_oe_q, sda_oe_d;
   logic       csn_q, csn_d;
   logic       rw_q, rw_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       busy_q, busy_d;

   // State and registered outputs; reset releases SDA and drops any strobe at once.
   always_ff @(posedge i_ck or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         rd_sh_q   <= '0;
         ptr_q     <= '0;
         rw_bit_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
         csn_q     <= 1'b1;
         rw_q      <= 1'b1;
         addr_q    <= '0;
         data_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         rd_sh_q   <= rd_sh_d;
         ptr_q     <= ptr_d;
         rw_bit_q  <= rw_bit_d;
         sda_oe_q  <= sda_oe_d;
         csn_q     <= csn_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
      end
   end

   // Protocol FSM: next state, bit shifting, SDA drive and register-file strobes.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      rd_sh_d   = rd_sh_q;
      ptr_d     = ptr_q;
      rw_bit_d  = rw_bit_q;
      sda_oe_d  = sda_oe_q;
      csn_d     = 1'b1;
      rw_d      = rw_q;
      addr_d    = addr_q;
      data_d    = data_q;
      busy_d    = busy_q;

      if (stop_det) begin
         state_d   = StIdle;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_det) begin
         // Repeated START keeps the pointer; any partial byte is dropped.
         state_d   = StDevAddr;
         sda_oe_d  = 1'b0;
         bit_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: ;

            StDevAddr: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     if (shreg_q[6:0] == SLAVE_ADDR) begin
                        state_d  = StAckAddr;
                        busy_d   = 1'b1;
                        rw_bit_d = sda_f;
                     end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                     end
                  end
               end
            end

            // First SCL fall starts the ACK; a read fetches on the ACK clock's rise so
            // the first data bit is ready when that clock falls.
            StAckAddr: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (!rw_bit_q) begin
                     sda_oe_d  = 1'b0;
                     state_d   = StRegPtr;
                     bit_cnt_d = '0;
                  end
               end else if (scl_rise && sda_oe_q && rw_bit_q) begin
                  state_d   = StRdFetch;
                  bit_cnt_d = '0;
               end
            end

            StRegPtr: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     ptr_d     = {shreg_q[2:0], sda_f};
                     state_d   = StAckPtr;
                     bit_cnt_d = '0;
                  end
               end
            end

            StAckPtr, StAckWData: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     state_d   = StWData;
                     bit_cnt_d = '0;
                  end
               end
            end

            StWData: begin
               if (scl_rise) begin
                  shreg_d   = {shreg_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     csn_d     = 1'b0;
                     rw_d      = 1'b0;
                     addr_d    = ptr_q;
                     data_d    = {shreg_q[6:0], sda_f};
                     ptr_d     = ptr_q + 4'd1;
                     state_d   = StAckWData;
                     bit_cnt_d = '0;
                  end
               end
            end

            // Cycle 0 issues the read strobe; read data is captured two cycles later.
            StRdFetch: begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd0) begin
                  csn_d  = 1'b0;
                  rw_d   = 1'b1;
                  addr_d = ptr_q;
               end
               if (bit_cnt_q == 4'd2) begin
                  rd_sh_d   = i_rdata;
                  state_d   = StRData;
                  bit_cnt_d = '0;
               end
            end

            StRData: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     state_d   = StRAck;
                     bit_cnt_d = '0;
                  end else begin
                     sda_oe_d  = ~rd_sh_q[7];
                     rd_sh_d   = {rd_sh_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end

            StRAck: begin
               if (scl_rise) begin
                  if (!sda_f) begin
                     ptr_d     = ptr_q + 4'd1;
                     state_d   = StRdFetch;
                     bit_cnt_d = '0;
                  end else begin
                     state_d = StIdle;
                     busy_d  = 1'b0;
                  end
               end
            end

            default: state_d = StIdle;
         endcase
      end
   end

   assign o_sda_oe  = sda_oe_q;
   assign o_csn     = csn_q;
   assign o_rw      = rw_q;
   assign o_address = addr_q;
   assign o_data    = data_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: bus-master tasks, a negedge register-file
// model, a table of write transactions, hand-written corner cases and randomized
// write/read-back against a transaction-level memory/pointer model.
module tb_i2c_slave_ctrl;

   localparam int unsigned Q = 5;  // quarter SCL bit period in i_ck cycles

   logic       i_ck = 1'b0;
   logic       i_rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       i_sda;
   logic [7:0] i_rdata = 8'h00;
   logic       o_sda_oe, o_csn, o_rw, o_busy;
   logic [3:0] o_address;
   logic [7:0] o_data;

   assign i_sda = sda_m & ~o_sda_oe;

   i2c_slave_ctrl #(
      .SLAVE_ADDR(7'h50),
      .FILTER_LEN(3)
   ) dut (
      .i_ck     (i_ck),
      .i_rst    (i_rst),
      .i_scl    (scl_m),
      .i_sda    (i_sda),
      .o_sda_oe (o_sda_oe),
      .o_csn    (o_csn),
      .o_rw     (o_rw),
      .o_address(o_address),
      .o_data   (o_data),
      .i_rdata  (i_rdata),
      .o_busy   (o_busy)
   );

   always #5 i_ck = ~i_ck;

   typedef struct packed {
      logic       rw;
      logic [3:0] addr;
      logic [7:0] data;
   } strobe_t;

   typedef struct {
      logic [7:0] dev;
      logic [7:0] ptr;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       ack;
      logic [3:0] a0;
      logic [3:0] a1;
   } wvec_t;

   strobe_t    slog[$];
   logic [7:0] mem [16];
   logic [7:0] mem_m [16];
   logic       mem_loaded = 1'b0;
   logic       prev_csn_low = 1'b0;
   int         csn_double_cnt = 0;
   int         sda_low_cnt = 0;
   int         busy_cnt = 0;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] wbuf [8];

   // Register-file model and bus monitor, sampled on the falling clock edge.
   always @(negedge i_ck) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'((i * 59) ^ 8'hC6);
         mem_loaded <= 1'b1;
      end
      if (!o_csn) begin
         slog.push_back({o_rw, o_address, o_data});
         if (o_rw) i_rdata <= mem[o_address];
         else mem[o_address] <= o_data;
         if (prev_csn_low) csn_double_cnt <= csn_double_cnt + 1;
      end
      prev_csn_low <= !o_csn;
      if (o_sda_oe) sda_low_cnt <= sda_low_cnt + 1;
      if (o_busy) busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected run to complete");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge i_ck);
      #1;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b1; cyc(2 * Q);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      sda_m = b;    cyc(Q);
      scl_m = 1'b1; cyc(Q);
      s = i_sda;    cyc(Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         d[i] = s;
      end
      bus_bit(~ack, s);
   endtask

   // START, dev, ptr, n data bytes from wbuf, STOP; model updates mem_m and checks strobes.
   task automatic write_txn(input logic [7:0] dev, input logic [7:0] ptr, input int n,
                            input logic exp_ack, input string tag);
      int         s0, l0, b0, c0;
      logic       a;
      logic [3:0] p;
      s0 = slog.size(); l0 = sda_low_cnt; b0 = busy_cnt; c0 = csn_double_cnt;
      bus_start();
      write_byte(dev, a);
      check($sformatf("%s devaddr ack", tag), a, exp_ack);
      write_byte(ptr, a);
      check($sformatf("%s ptr ack", tag), a, exp_ack);
      for (int i = 0; i < n; i++) begin
         write_byte(wbuf[i], a);
         check($sformatf("%s data%0d ack", tag, i), a, exp_ack);
      end
      check($sformatf("%s busy before stop", tag), o_busy, exp_ack);
      bus_stop();
      check($sformatf("%s busy after stop", tag), o_busy, 0);
      check($sformatf("%s strobe count", tag), slog.size() - s0, exp_ack ? n : 0);
      check($sformatf("%s csn double low", tag), csn_double_cnt - c0, 0);
      if (!exp_ack) begin
         check($sformatf("%s sda never low", tag), sda_low_cnt - l0, 0);
         check($sformatf("%s busy never set", tag), busy_cnt - b0, 0);
      end else begin
         p = ptr[3:0];
         for (int i = 0; i < n && s0 + i < slog.size(); i++) begin
            check($sformatf("%s strobe%0d", tag, i), int'(slog[s0 + i]), int'({1'b0, p, wbuf[i]}));
            mem_m[p] = wbuf[i];
            p = 4'((p + 1) % 16);
         end
      end
   endtask

   // Set pointer, repeated START, read n bytes (ACK all but the last), STOP.
   task automatic read_txn(input logic [3:0] ptr, input int n, input string tag);
      int         s0;
      logic       a;
      logic [7:0] d;
      int         exp_a;
      s0 = slog.size();
      bus_start();
      write_byte(8'hA0, a);
      check($sformatf("%s devaddr ack", tag), a, 1);
      write_byte({4'h0, ptr}, a);
      check($sformatf("%s ptr ack", tag), a, 1);
      bus_start();
      write_byte(8'hA1, a);
      check($sformatf("%s rd devaddr ack", tag), a, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(i < n - 1, d);
         check($sformatf("%s rdata%0d", tag, i), d, mem_m[(ptr + i) % 16]);
      end
      check($sformatf("%s busy after nack", tag), o_busy, 0);
      bus_stop();
      check($sformatf("%s read strobe count", tag), slog.size() - s0, n);
      for (int i = 0; i < n && s0 + i < slog.size(); i++) begin
         exp_a = (ptr + i) % 16;
         check($sformatf("%s rstrobe%0d", tag, i), {slog[s0 + i].rw, slog[s0 + i].addr},
               {1'b1, 4'(exp_a)});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check($sformatf("%s sda_oe", tag), o_sda_oe, 0);
      check($sformatf("%s csn", tag), o_csn, 1);
      check($sformatf("%s rw", tag), o_rw, 1);
      check($sformatf("%s address", tag), o_address, 0);
      check($sformatf("%s data", tag), o_data, 0);
      check($sformatf("%s busy", tag), o_busy, 0);
   endtask

   initial begin
      wvec_t      tbl [4];
      logic       a, s;
      logic [7:0] d;
      int         s0, n, p;

      tbl[0] = '{dev: 8'hA0, ptr: 8'h03, d0: 8'hA5, d1: 8'h5A, ack: 1'b1, a0: 4'h3, a1: 4'h4};
      tbl[1] = '{dev: 8'hA0, ptr: 8'h0F, d0: 8'h11, d1: 8'h22, ack: 1'b1, a0: 4'hF, a1: 4'h0};
      tbl[2] = '{dev: 8'hA2, ptr: 8'h00, d0: 8'h77, d1: 8'h88, ack: 1'b0, a0: 4'h0, a1: 4'h0};
      tbl[3] = '{dev: 8'hA0, ptr: 8'hB7, d0: 8'h3C, d1: 8'hC3, ack: 1'b1, a0: 4'h7, a1: 4'h8};

      for (int i = 0; i < 16; i++) mem_m[i] = 8'((i * 59) ^ 8'hC6);

      cyc(3);
      check_reset_outputs("reset");
      i_rst = 1'b0;
      cyc(10);

      // Table-driven write transactions.
      for (int t = 0; t < 4; t++) begin
         s0 = slog.size();
         wbuf[0] = tbl[t].d0;
         wbuf[1] = tbl[t].d1;
         write_txn(tbl[t].dev, tbl[t].ptr, 2, tbl[t].ack, $sformatf("wr%0d", t));
         if (tbl[t].ack && slog.size() >= s0 + 2) begin
            check($sformatf("wr%0d addr0", t), slog[s0].addr, tbl[t].a0);
            check($sformatf("wr%0d addr1", t), slog[s0 + 1].addr, tbl[t].a1);
         end
      end

      // Read back regs 3 and 4 via repeated START.
      read_txn(4'h3, 2, "rd34");

      // STOP after 4 data bits: partial byte must not strobe.
      s0 = slog.size();
      bus_start();
      write_byte(8'hA0, a);
      check("abort devaddr ack", a, 1);
      write_byte(8'h05, a);
      check("abort ptr ack", a, 1);
      for (int i = 0; i < 4; i++) bus_bit(1'b0, s);
      bus_stop();
      check("abort no strobe", slog.size() - s0, 0);
      check("abort busy", o_busy, 0);

      // Reset in the middle of a read while the slave is pulling SDA low.
      wbuf[0] = 8'h00;
      write_txn(8'hA0, 8'h06, 1, 1'b1, "pre6");
      bus_start();
      write_byte(8'hA0, a);
      write_byte(8'h06, a);
      bus_start();
      write_byte(8'hA1, a);
      check("rstmid devaddr ack", a, 1);
      for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
      check("rstmid slave driving", o_sda_oe, 1);
      i_rst = 1'b1;
      #1;
      check_reset_outputs("rstmid");
      sda_m = 1'b1;
      scl_m = 1'b1;
      cyc(4);
      i_rst = 1'b0;
      cyc(10);

      // After reset the pointer is 0: read from the current pointer.
      s0 = slog.size();
      bus_start();
      write_byte(8'hA1, a);
      check("ptr0 devaddr ack", a, 1);
      read_byte(1'b0, d);
      check("ptr0 rdata", d, mem_m[0]);
      bus_stop();
      check("ptr0 strobe count", slog.size() - s0, 1);
      if (slog.size() > s0) check("ptr0 strobe addr", slog[s0].addr, 0);

`ifdef I2C_GLITCH_FILTER_EN
      // One-cycle SDA dip while SCL is high must not look like a START.
      s0 = sda_low_cnt;
      n  = busy_cnt;
      sda_m = 1'b0;
      cyc(1);
      sda_m = 1'b1;
      cyc(20);
      scl_m = 1'b0;
      cyc(Q);
      write_byte(8'hA0, a);
      check("glitch no ack", a, 0);
      check("glitch busy", busy_cnt - n, 0);
      check("glitch sda", sda_low_cnt - s0, 0);
      sda_m = 1'b1;
      scl_m = 1'b1;
      cyc(10);
`endif

      // Randomized write bursts and read-back against the model.
      for (int k = 0; k < 8; k++) begin
         p = $urandom_range(0, 15);
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         write_txn(8'hA0, 8'(p), n, 1'b1, $sformatf("rw%0d", k));
         p = $urandom_range(0, 15);
         n = $urandom_range(1, 4);
         read_txn(4'(p), n, $sformatf("rr%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
